// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, parity modes,
// baud divider and frame parity calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Unused high bits of data must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head output; full/empty derive from
// an occupancy register so the head is valid the cycle after the first push.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] head_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == CNT_FULL);
  assign empty   = (count_r == '0);
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);
  assign rd_data = head_r;
  assign count   = count_r;

  // Storage array, written at the tail pointer
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the prefetched head register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A pop of the last entry with a concurrent push forwards the new word.
      if (do_rd_s) begin
        if (count_r > CNT_ONE) head_r <= mem_r[rd_ptr_r + PTR_ONE];
        else if (do_wr_s)      head_r <= wr_data;
        else                   head_r <= head_r;
      end else if (empty && do_wr_s) begin
        head_r <= wr_data;
      end else begin
        head_r <= head_r;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_transceiver.sv
// Direct-pin UART with TX/RX FIFOs, configurable framing and sticky
// framing/parity/overrun error flags.
module uart_fifo_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic                          txd,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  input  logic                          err_clear,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  uart_state_t          tx_state_r;
  logic [CW-1:0]        tx_cnt_r;
  logic [BW-1:0]        tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_par_r;
  logic                 txd_r;
  logic [DATA_BITS-1:0] tx_head_s;
  logic                 tx_full_s;
  logic                 tx_empty_s;
  logic                 tx_pop_s;

  uart_state_t          rx_state_r;
  logic [CW-1:0]        rx_cnt_r;
  logic [BW-1:0]        rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic                 rx_par_r;
  logic [1:0]           rx_sync_r;
  logic                 rx_prev_r;
  logic                 rx_wr_r;
  logic [DATA_BITS-1:0] rx_wr_data_r;
  logic                 rx_full_s;
  logic                 rx_empty_s;
  logic                 rx_bit_s;
  logic                 stop_sample_s;
  logic                 fe_set_s;
  logic                 pe_set_s;
  logic                 ov_set_s;
  logic                 frame_err_r;
  logic                 parity_err_r;
  logic                 overrun_r;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr_en(tx_valid), .wr_data(tx_data), .rd_en(tx_pop_s),
    .rd_data(tx_head_s), .count(tx_count), .full(tx_full_s), .empty(tx_empty_s)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr_en(rx_wr_r), .wr_data(rx_wr_data_r), .rd_en(rx_ready),
    .rd_data(rx_data), .count(rx_count), .full(rx_full_s), .empty(rx_empty_s)
  );

  assign tx_ready = !tx_full_s;
  assign rx_valid = !rx_empty_s;
  assign txd      = txd_r;

  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop_s = !tx_empty_s &&
                    ((tx_state_r == IDLE) || ((tx_state_r == STOP) && (tx_cnt_r == STOP_END)));

  // TX sequencer: start bit, data LSB first, optional parity, stop bits
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= '0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      txd_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        IDLE, STOP: begin
          if ((tx_state_r == STOP) && (tx_cnt_r != STOP_END)) begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end else if (tx_pop_s) begin
            tx_cnt_r   <= '0;
            tx_shift_r <= tx_head_s;
            tx_par_r   <= calc_parity(8'(tx_head_s), PARITY);
            txd_r      <= 1'b0;
            tx_state_r <= START;
          end else begin
            tx_cnt_r   <= '0;
            txd_r      <= 1'b1;
            tx_state_r <= IDLE;
          end
        end
        START: begin
          if (tx_cnt_r == DIV_END) begin
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            txd_r      <= tx_shift_r[0];
            tx_state_r <= DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (tx_cnt_r == DIV_END) begin
            tx_cnt_r <= '0;
            if (tx_bit_r != LAST_BIT) begin
              txd_r      <= tx_shift_r[1];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx_bit_r   <= tx_bit_r + BIT_ONE;
            end else if (PARITY != PARITY_NONE) begin
              txd_r      <= tx_par_r;
              tx_state_r <= uart_pkg::PARITY;
            end else begin
              txd_r      <= 1'b1;
              tx_state_r <= STOP;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        uart_pkg::PARITY: begin
          if (tx_cnt_r == DIV_END) begin
            tx_cnt_r   <= '0;
            txd_r      <= 1'b1;
            tx_state_r <= STOP;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        default: begin
          tx_cnt_r   <= '0;
          txd_r      <= 1'b1;
          tx_state_r <= IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_r <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rxd};
      rx_prev_r <= rx_sync_r[1];
    end
  end

  assign rx_bit_s      = rx_sync_r[1];
  assign stop_sample_s = (rx_state_r == STOP) && (rx_cnt_r == DIV_END);
  assign fe_set_s      = stop_sample_s && !rx_bit_s;
  assign ov_set_s      = stop_sample_s && rx_bit_s && rx_full_s;
  assign pe_set_s      = stop_sample_s && rx_bit_s && (PARITY != PARITY_NONE) &&
                         (calc_parity(8'(rx_shift_r), PARITY) != rx_par_r);

  // RX sequencer: mid-bit sampling from the start edge, push at mid-stop
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r   <= IDLE;
      rx_cnt_r     <= '0;
      rx_bit_r     <= '0;
      rx_shift_r   <= '0;
      rx_par_r     <= 1'b0;
      rx_wr_r      <= 1'b0;
      rx_wr_data_r <= '0;
    end else begin
      rx_wr_r <= 1'b0;
      case (rx_state_r)
        IDLE: begin
          rx_cnt_r <= '0;
          if (rx_prev_r && !rx_bit_s) rx_state_r <= START;
        end
        START: begin
          if (rx_cnt_r == HALF_END) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= '0;
            rx_state_r <= rx_bit_s ? IDLE : DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (rx_cnt_r == DIV_END) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_bit_s, rx_shift_r[DATA_BITS-1:1]};
            rx_bit_r   <= rx_bit_r + BIT_ONE;
            if (rx_bit_r == LAST_BIT) begin
              rx_state_r <= (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        uart_pkg::PARITY: begin
          if (rx_cnt_r == DIV_END) begin
            rx_cnt_r   <= '0;
            rx_par_r   <= rx_bit_s;
            rx_state_r <= STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (stop_sample_s) begin
            rx_cnt_r   <= '0;
            rx_state_r <= IDLE;
            rx_wr_r    <= rx_bit_s && !rx_full_s;
            rx_wr_data_r <= rx_shift_r;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        default: begin
          rx_cnt_r   <= '0;
          rx_state_r <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r  <= fe_set_s || (frame_err_r  && !err_clear);
      parity_err_r <= pe_set_s || (parity_err_r && !err_clear);
      overrun_r    <= ov_set_s || (overrun_r    && !err_clear);
    end
  end

  assign rx_frame_err  = frame_err_r;
  assign rx_parity_err = parity_err_r;
  assign rx_overrun    = overrun_r;

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Bench: a default-configured instance in txd->rxd loopback plus an even-parity,
// depth-4 instance whose rxd is bit-banged; RX output checked by scoreboard.
module tb_uart_fifo_transceiver;

  localparam int DIV0 = 50_000_000 / 115200;
  localparam int DIV1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, txd0, tx_valid0, tx_ready0, rx_valid0, rx_ready0;
  logic       fe0, pe0, ov0, err_clear0;
  logic [7:0] tx_data0, rx_data0;
  logic [4:0] tx_count0, rx_count0;

  logic       rst1, rxd1, txd1, tx_valid1, tx_ready1, rx_valid1, rx_ready1;
  logic       fe1, pe1, ov1, err_clear1;
  logic [7:0] tx_data1, rx_data1;
  logic [2:0] tx_count1, rx_count1;

  uart_fifo_transceiver #(.CLK_FREQ(50_000_000), .BAUD(115200), .DATA_BITS(8),
                          .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .rst(rst0), .rxd(txd0), .txd(txd0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_overrun(ov0), .err_clear(err_clear0),
    .tx_count(tx_count0), .rx_count(rx_count0)
  );

  uart_fifo_transceiver #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                          .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst1), .rxd(rxd1), .txd(txd1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_overrun(ov1), .err_clear(err_clear1),
    .tx_count(tx_count1), .rx_count(rx_count1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  logic m_fe, m_pe, m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every DUT pop is compared with the oldest expected byte
  always @(negedge clk) begin
    if (!rst0 && rx_valid0 && rx_ready0) begin
      if (exp0_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx0 unexpected pop: got %0h expected nothing", rx_data0);
      end else check("rx0 data", rx_data0, exp0_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst1 && rx_valid1 && rx_ready1) begin
      if (exp1_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx1 unexpected pop: got %0h expected nothing", rx_data1);
      end else check("rx1 data", rx_data1, exp1_q.pop_front());
    end
  end

  task automatic drain0(input int budget);
    for (int i = 0; i < budget && exp0_q.size() != 0; i++) tick();
    check("rx0 drained", exp0_q.size(), 0);
  endtask

  task automatic drain1(input int budget);
    for (int i = 0; i < budget && exp1_q.size() != 0; i++) tick();
    check("rx1 drained", exp1_q.size(), 0);
  endtask

  // Reference model of one received frame on dut1 (even parity, depth 4)
  task automatic model_frame1(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    if (!stop_bit) m_fe = 1'b1;
    else begin
      if (par_bit != (^d)) m_pe = 1'b1;
      if (exp1_q.size() >= 4) m_ov = 1'b1;
      else exp1_q.push_back(d);
    end
  endtask

  task automatic send_frame1(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    model_frame1(d, par_bit, stop_bit);
    rxd1 = 1'b0;
    repeat (DIV1) tick();
    for (int i = 0; i < 8; i++) begin
      rxd1 = d[i];
      repeat (DIV1) tick();
    end
    rxd1 = par_bit;
    repeat (DIV1) tick();
    rxd1 = stop_bit;
    repeat (DIV1) tick();
    rxd1 = 1'b1;
    repeat (2 * DIV1) tick();
    @(negedge clk);
    check("rx1 frame_err", fe1, m_fe);
    check("rx1 parity_err", pe1, m_pe);
    check("rx1 overrun", ov1, m_ov);
  endtask

  task automatic clear1();
    err_clear1 = 1'b1;
    tick();
    err_clear1 = 1'b0;
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       expbit;
    int         good, rdy;
    int         kind;

    rst0 = 1'b1; tx_valid0 = 1'b0; tx_data0 = 8'h00; rx_ready0 = 1'b0; err_clear0 = 1'b0;
    rst1 = 1'b1; rxd1 = 1'b1; tx_valid1 = 1'b0; tx_data1 = 8'h00; rx_ready1 = 1'b0;
    err_clear1 = 1'b0;
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset txd0", txd0, 1);
    check("reset tx_ready0", tx_ready0, 1);
    check("reset rx_valid0", rx_valid0, 0);
    check("reset rx_data0", rx_data0, 0);
    check("reset counts0", {tx_count0, rx_count0}, 0);
    check("reset flags0", {fe0, pe0, ov0}, 0);
    check("reset txd1", txd1, 1);
    check("reset flags1", {fe1, pe1, ov1, rx_valid1}, 0);
    tick();
    rst0 = 1'b0; rst1 = 1'b0;

    // Waveform of 8'h32 on the default instance
    rx_ready0 = 1'b1;
    b = 8'h32;
    tx_data0 = b; tx_valid0 = 1'b1;
    exp0_q.push_back(b);
    tick();
    tx_valid0 = 1'b0;
    @(negedge clk);
    check("tx0 idle before start", txd0, 1);
    rdy = 0;
    for (int k = 0; k < 10; k++) begin
      expbit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      good = 0;
      repeat (DIV0) begin
        @(negedge clk);
        if (txd0 === expbit) good++;
        if (tx_ready0 === 1'b1) rdy++;
      end
      check($sformatf("tx0 bit %0d cycles", k), good, DIV0);
    end
    check("tx0 ready held", rdy, 10 * DIV0);
    drain0(2 * DIV0);

    // Back-to-back loopback frames accumulate in the RX FIFO
    rx_ready0 = 1'b0;
    tx_valid0 = 1'b1; tx_data0 = 8'h32; exp0_q.push_back(8'h32);
    tick();
    tx_data0 = 8'h33; exp0_q.push_back(8'h33);
    tick();
    tx_valid0 = 1'b0;
    for (int i = 0; i < 30 * DIV0 && rx_count0 != 5'd2; i++) tick();
    @(negedge clk);
    check("rx0 count two", rx_count0, 2);
    check("rx0 flags clean", {fe0, pe0, ov0}, 0);
    tick();
    rx_ready0 = 1'b1;
    drain0(20);

    // Random bytes through the loopback with a randomly stalling consumer
    tx_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data0 = 8'($urandom);
      exp0_q.push_back(tx_data0);
      tick();
    end
    tx_valid0 = 1'b0;
    for (int i = 0; i < 35 * DIV0 && exp0_q.size() != 0; i++) begin
      rx_ready0 = ($urandom_range(0, 3) != 0);
      tick();
    end
    rx_ready0 = 1'b1;
    drain0(20);
    @(negedge clk);
    check("rx0 flags after random", {fe0, pe0, ov0}, 0);

    // Even parity: 8'h33 with parity bit 1 is a mismatch but still delivered
    rx_ready1 = 1'b1;
    send_frame1(8'h33, 1'b1, 1'b1);
    check("rx1 parity flag set", pe1, 1);
    drain1(20);
    tick();
    clear1();
    @(negedge clk);
    check("rx1 parity flag cleared", pe1, 0);

    // Low stop bit drops the frame
    tick();
    rx_ready1 = 1'b0;
    send_frame1(8'h55, ^8'h55, 1'b0);
    check("rx1 frame_err set", fe1, 1);
    check("rx1 count after frame_err", rx_count1, 0);
    tick();
    clear1();

    // Short low glitch must not start a frame
    rxd1 = 1'b0;
    repeat (3) tick();
    rxd1 = 1'b1;
    repeat (3 * DIV1) tick();
    @(negedge clk);
    check("rx1 glitch flags", {fe1, pe1, ov1}, 0);
    check("rx1 glitch count", rx_count1, 0);

    // Overrun: five frames into a depth-4 FIFO with no consumer
    tick();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame1(b, ^b, 1'b1);
    end
    check("rx1 count full", rx_count1, exp1_q.size());
    check("rx1 overrun set", ov1, 1);
    tick();
    rx_ready1 = 1'b1;
    drain1(20);
    tick();
    clear1();

    // Randomised frames with occasional parity/stop errors and clears
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) clear1();
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame1(b, (kind == 0) ? ~(^b) : (^b), (kind == 1) ? 1'b0 : 1'b1);
    end
    drain1(20);

    // Reset during the TX data phase of dut1
    tick();
    tx_data1 = 8'h00; tx_valid1 = 1'b1;
    tick();
    tx_valid1 = 1'b0;
    tick();
    tx_data1 = 8'h00; tx_valid1 = 1'b1;
    tick();
    tx_valid1 = 1'b0;
    repeat (DIV1 + 4) tick();
    @(negedge clk);
    check("tx1 data phase low", txd1, 0);
    check("tx1 count before reset", tx_count1, 1);
    tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    @(negedge clk);
    check("tx1 txd after reset", txd1, 1);
    check("tx1 count after reset", tx_count1, 0);
    good = 0;
    repeat (2 * DIV1) begin
      @(negedge clk);
      if (txd1 === 1'b1) good++;
    end
    check("tx1 stays idle", good, 2 * DIV1);

    check("rx0 queue empty", exp0_q.size(), 0);
    check("rx1 queue empty", exp1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
